// File: rtl/systolic_controller.sv
// Sequencer for an NxN output-stationary systolic array: clears the PE
// accumulators, drives the skewed A/B feeder schedule for 3N-2 cycles, then
// streams the N*N results out in row-major order under valid/ready handshake.
module systolic_controller #(
  parameter int N = 4,
  localparam int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            array_clr_n,
  output logic            array_en,
  output logic [N-1:0]    a_feed_valid,
  output logic [N*IW-1:0] a_feed_idx,
  output logic [N-1:0]    b_feed_valid,
  output logic [N*IW-1:0] b_feed_idx,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [IW-1:0]   res_row,
  output logic [IW-1:0]   res_col
);

  // Cycle counter is wide enough for 3N; the wrap-around subtraction below
  // relies on 2**TW >= 3N so that t < gi maps to a value >= N.
  localparam int TW = $clog2(3 * N);
  localparam logic [TW-1:0] T_LAST   = TW'(3 * N - 3);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COMPUTE,
    READOUT,
    DONE
  } state_t;

  state_t          state;
  logic [TW-1:0]   t_cnt;
  logic [N-1:0]    feed_valid;
  logic [N*IW-1:0] feed_idx;

  // Main FSM: state, compute-cycle counter, readout beat coordinates and the
  // control outputs all update together so every output is a flop or a pure
  // decode of flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      t_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      array_clr_n <= 1'b1;
      array_en    <= 1'b0;
      res_valid   <= 1'b0;
      res_row     <= '0;
      res_col     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= CLEAR;
            busy        <= 1'b1;
            array_clr_n <= 1'b0;
          end
        end
        CLEAR: begin
          state       <= COMPUTE;
          t_cnt       <= '0;
          array_clr_n <= 1'b1;
          array_en    <= 1'b1;
        end
        COMPUTE: begin
          if (t_cnt == T_LAST) begin
            state     <= READOUT;
            t_cnt     <= '0;
            array_en  <= 1'b0;
            res_valid <= 1'b1;
            res_row   <= '0;
            res_col   <= '0;
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        READOUT: begin
          if (res_ready) begin
            if (res_col == IDX_LAST) begin
              res_col <= '0;
              if (res_row == IDX_LAST) begin
                state     <= DONE;
                res_valid <= 1'b0;
                res_row   <= '0;
                done      <= 1'b1;
              end else begin
                res_row <= res_row + 1'b1;
              end
            end else begin
              res_col <= res_col + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          t_cnt       <= '0;
          busy        <= 1'b0;
          done        <= 1'b0;
          array_clr_n <= 1'b1;
          array_en    <= 1'b0;
          res_valid   <= 1'b0;
          res_row     <= '0;
          res_col     <= '0;
        end
      endcase
    end
  end

  // Skewed feeder schedule: lane gi is active for t in [gi, gi+N-1] and
  // streams k = t - gi. A and B lanes share the same schedule.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_feed
      localparam logic [TW-1:0] LANE_OFS = TW'(gi);
      logic [TW-1:0] lane_k;
      assign lane_k = t_cnt - LANE_OFS;
      assign feed_valid[gi] = (state == COMPUTE) && (lane_k < TW'(N));
      assign feed_idx[gi*IW +: IW] = feed_valid[gi] ? lane_k[IW-1:0] : '0;
    end
  endgenerate

  assign a_feed_valid = feed_valid;
  assign a_feed_idx   = feed_idx;
  assign b_feed_valid = feed_valid;
  assign b_feed_idx   = feed_idx;

endmodule
